seq_alu: RTL
============

Name: seq_alu

Overview:
- Registered, parametrised ALU with a valid/ready handshake on both input and output.
- Keeps the established 4-bit Func encoding: Func[3] inverts operand B and supplies carry-in.
- Adds signed SLT, shifts, status flags and an optional iterative multiplier.
- Sits between the register-read and writeback stages of the multi-cycle datapath. The control FSM stalls on in_ready and out_valid.

Parameters:
- WIDTH, 32: operand/result width; power of two, at least 4.
- SHW, $clog2(WIDTH): shift-amount width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and Func are valid
- in_ready  output  1  block can accept an operation this cycle
- func  input  4  operation select
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B / shift amount (in2[SHW-1:0])
- out_valid  output  1  result and flags are valid
- out_ready  input  1  consumer takes the result this cycle
- alu_out  output  WIDTH  result
- zero  output  1  alu_out == 0
- neg  output  1  alu_out[WIDTH-1]
- carry  output  1  carry-out (ADD/SUB), high-half-nonzero (MUL), else 0
- ovf  output  1  signed overflow (ADD/SUB only), else 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; alu_out, all flags and out_valid = 0.
  - in_ready = 1 from the first edge after release.
- Operand conditioning: B = func[3] ? ~in2 : in2. Sum = in1 + B + func[3], WIDTH+1 bits; carry = bit WIDTH.
- func[2:0] decode:
  - 000 AND, 001 OR, 010 XOR, 011 XNOR (each on in1 and B)
  - 100 ADD/SUB (SUB when func[3]=1)
  - 101 SLT signed; requires func[3]=1. Result = {0…, sum[MSB] ^ ovf}.
  - 110 shift: func[3]=0 gives SLL, func[3]=1 gives SRL (logical). Amount is in2[SHW-1:0]; upper in2 bits are ignored.
  - 111 MUL, unsigned low WIDTH bits; func[3] ignored.
- ovf = (in1[MSB] == B[MSB]) && (sum[MSB] != in1[MSB]), for 100 and 101 only.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept = in_valid && in_ready.
- Non-MUL accept:
  - Result and flags are registered on the accept edge; the FSM goes to DONE.
  - out_valid is high in the following cycle (latency 1).
- MUL accept:
  - Latch operands, clear the 2*WIDTH accumulator, counter = WIDTH, go to BUSY.
  - Each BUSY cycle is one shift-add step; the counter decrements.
  - When the counter reaches 0, register the result and go to DONE. out_valid rises exactly WIDTH cycles after the accept edge.
  - in_ready = 0 throughout BUSY.
- DONE:
  - out_valid=1. alu_out and flags hold stable until out_ready=1.
  - On out_ready with no new accept, go to IDLE and drop out_valid next cycle.
  - On out_ready with a simultaneous accept, load the new operation. Back-to-back single-cycle ops sustain one result per cycle.
- Changes on in1/in2/func while BUSY are ignored (operands are latched).
- Reset mid-BUSY aborts the operation. No partial result is presented.
- Undefined encodings do not exist. 101 with func[3]=0 still computes sign(in1+in2) and is not used by control.

Optional Feature:
- Macro SEQ_ALU_MUL_EN.
- Defined: MUL is implemented as above.
- Undefined:
  - No multiplier or BUSY-state hardware.
  - Opcode 111 completes in 1 cycle with alu_out=0, zero=1, carry=0, ovf=0.
  - Handshake timing is identical to other single-cycle ops.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, alu_out=0, all flags 0; in_ready=1 after release.
- ADD func=0100, in1=0x7FFFFFFF, in2=1 -> next cycle alu_out=0x80000000, ovf=1, neg=1, carry=0, zero=0.
- SUB func=1100, 5-5 -> alu_out=0, zero=1, carry=1. SLT func=1101:
  - -1 vs 1 gives 1.
  - 0x7FFFFFFF vs 0x80000000 gives 0 (overflow-corrected).
- Shifts:
  - SLL func=0110, in1=1, in2=0x0000003F gives 0x80000000 (amount 31).
  - SRL func=1110, in1=0x80000000, in2=4 gives 0x08000000.
- MUL (SEQ_ALU_MUL_EN) 0x00010000*0x00010000:
  - in_ready=0 for 32 cycles; out_valid rises 32 cycles after accept.
  - alu_out=0, zero=1, carry=1.
  - 7*6 gives 42, carry=0.
- Backpressure and reset:
  - out_ready=0 for 5 cycles holds alu_out/flags stable with in_ready=0.
  - Back-to-back ADDs with out_ready=1 give one result per cycle.
  - rst_n pulse mid-MUL gives out_valid=0 and in_ready=1 after release.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshakes on input and output.
// func[3] inverts operand B and supplies the carry-in; func[2:0] picks the
// operation (logic ops, ADD/SUB, signed SLT, shifts, MUL).
// Optional macro SEQ_ALU_MUL_EN: when defined, opcode 111 runs an iterative
// WIDTH-cycle shift-add multiplier; when undefined, 111 completes in one
// cycle with a zero result and no multiplier hardware exists.
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       func,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic             zero,
   output logic             neg,
   output logic             carry,
   output logic             ovf
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DONE = 2'd2;
`ifdef SEQ_ALU_MUL_EN
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
   localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);
`endif

   logic [1:0]       state;
   logic             rdy_en;     // holds in_ready low until the first edge after reset
   logic             accept;
   logic [WIDTH-1:0] b_op;
   logic [WIDTH:0]   sum;
   logic             sum_ovf;
   logic [WIDTH-1:0] res;
   logic             res_c;
   logic             res_v;

`ifdef SEQ_ALU_MUL_EN
   logic             is_mul;
   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_step;
   logic [SHW:0]     cnt;
`endif

   assign in_ready  = rdy_en && ((state == IDLE) || ((state == DONE) && out_ready));
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;

   // Single-cycle datapath: operand conditioning, adder and result mux
   always_comb begin
      b_op    = func[3] ? ~in2 : in2;
      sum     = {1'b0, in1} + {1'b0, b_op} + {{WIDTH{1'b0}}, func[3]};
      sum_ovf = (in1[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      res     = '0;
      res_c   = 1'b0;
      res_v   = 1'b0;
      case (func[2:0])
         3'b000: res = in1 & b_op;
         3'b001: res = in1 | b_op;
         3'b010: res = in1 ^ b_op;
         3'b011: res = ~(in1 ^ b_op);
         3'b100: begin
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = sum_ovf;
         end
         3'b101: begin
            // signed less-than: sign of the difference, corrected for overflow
            res   = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sum_ovf};
            res_v = sum_ovf;
         end
         3'b110: res = func[3] ? (in1 >> in2[SHW-1:0]) : (in1 << in2[SHW-1:0]);
         default: res = '0;   // 111: MUL goes through the iterative path when enabled
      endcase
   end

`ifdef SEQ_ALU_MUL_EN
   assign is_mul = (func[2:0] == 3'b111);

   // MSB-first shift-add step: acc = 2*acc + (current multiplier bit ? a : 0)
   always_comb begin
      acc_step = (acc << 1) + {{WIDTH{1'b0}}, (mul_b[WIDTH-1] ? mul_a : {WIDTH{1'b0}})};
   end

   // Multiplier operand latch and per-cycle iteration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_a <= '0;
         mul_b <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else if (accept && is_mul) begin
         mul_a <= in1;
         mul_b <= in2;
         acc   <= '0;
         cnt   <= CNT_INIT;
      end else if (state == BUSY) begin
         acc   <= acc_step;
         mul_b <= mul_b << 1;
         cnt   <= cnt - CNT_ONE;
      end
   end
`endif

   // Control FSM plus result/flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rdy_en  <= 1'b0;
         alu_out <= '0;
         zero    <= 1'b0;
         neg     <= 1'b0;
         carry   <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         case (state)
`ifdef SEQ_ALU_MUL_EN
            BUSY: begin
               if (cnt == CNT_ONE) begin
                  state   <= DONE;
                  alu_out <= acc_step[WIDTH-1:0];
                  zero    <= (acc_step[WIDTH-1:0] == '0);
                  neg     <= acc_step[WIDTH-1];
                  carry   <= |acc_step[2*WIDTH-1:WIDTH];
                  ovf     <= 1'b0;
               end
            end
`endif
            default: begin
               if (accept) begin
`ifdef SEQ_ALU_MUL_EN
                  if (is_mul) begin
                     state <= BUSY;
                  end else
`endif
                  begin
                     state   <= DONE;
                     alu_out <= res;
                     zero    <= (res == '0);
                     neg     <= res[WIDTH-1];
                     carry   <= res_c;
                     ovf     <= res_v;
                  end
               end else if ((state != DONE) || out_ready) begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule
